// File: rtl/synth_bus_arbiter.sv
// synth_bus_arbiter: shares the synth engine parameter bus between the CPU slave
// port (waitrequest handshake) and the MIDI/sysex decoder, and holds the common
// per-part MIDI channel/omni registers.
// Optional build macro SYNTH_ARB_FAIR_EN: bounds CPU starvation to STARVE_MAX
// consecutive decoder grants. Undefined: strict decoder priority.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate, latch owner/target/address/data, issue strobe
// ACCESS   | engine strobe cycle; com/unmapped accesses resolve here
// RD_WAIT  | engine read latency, data captured on the last wait cycle
// DONE     | one-cycle completion (dec_ack or cpu_waitrequest low)
module synth_bus_arbiter #(
    parameter int PARTS      = 4,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                 reg_clk,
    input  logic                 reset_reg_n,
    input  logic                 cpu_cs,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [9:0]           cpu_address,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_waitrequest,
    input  logic                 dec_req,
    input  logic                 dec_rw,
    input  logic [4:0]           dec_sel,
    input  logic [6:0]           dec_addr,
    input  logic [7:0]           dec_wdata,
    output logic                 dec_ack,
    output logic [7:0]           dec_rdata,
    output logic [3:0]           eng_sel,
    output logic [6:0]           eng_adr,
    output logic                 eng_write,
    output logic                 eng_read,
    output logic [7:0]           eng_wdata,
    input  logic [7:0]           eng_rdata,
    output logic [4*PARTS-1:0]   part_midi_ch,
    output logic [PARTS-1:0]     part_omni
);

    localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_lat
        $error("READ_LAT out of range");
    end
    if (STARVE_MAX < 1 || PARTS < 1 || PARTS > 16) begin : g_bad_cfg
        $error("STARVE_MAX/PARTS out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_DONE} state_t;

    state_t           state;
    logic             owner_dec;
    logic             acc_write;
    logic             acc_com;
    logic [WCW-1:0]   wait_cnt;

    logic             cpu_req;
    logic             grant_cpu;
    logic             grant_dec;
    logic             nx_write;
    logic             nx_com;
    logic [3:0]       nx_eng;
    logic [6:0]       nx_adr;
    logic [7:0]       nx_wdata;
    logic [7:0]       com_rd;

`ifdef SYNTH_ARB_FAIR_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);
    logic [SCW-1:0]   starve_left;
`endif

    // Arbitration and decode of the winning master's request into a bus access
    always_comb begin
        cpu_req = cpu_cs & (cpu_read | cpu_write);
`ifdef SYNTH_ARB_FAIR_EN
        grant_cpu = cpu_req & (~dec_req | (starve_left == '0));
`else
        grant_cpu = cpu_req & ~dec_req;
`endif
        grant_dec = dec_req & ~grant_cpu;
        nx_eng    = '0;
        nx_com    = 1'b0;
        nx_write  = ~cpu_read;
        nx_adr    = cpu_address[6:0];
        nx_wdata  = cpu_wdata;
        if (grant_dec) begin
            nx_write = dec_rw;
            nx_adr   = dec_addr;
            nx_wdata = dec_wdata;
            case (dec_sel)
                5'b00001: nx_eng = 4'b0001;
                5'b00010: nx_eng = 4'b0010;
                5'b00100: nx_eng = 4'b0100;
                5'b01000: nx_eng = 4'b1000;
                5'b10000: nx_com = 1'b1;
                default:  nx_eng = 4'b0000;
            endcase
        end else begin
            case (cpu_address[9:7])
                3'd0:    nx_eng = 4'b0001;
                3'd1:    nx_eng = 4'b0010;
                3'd2:    nx_eng = 4'b0100;
                3'd3:    nx_eng = 4'b1000;
                3'd5:    nx_com = 1'b1;
                default: nx_eng = 4'b0000;
            endcase
        end
    end

    // Common-register read mux; out-of-range part addresses and unmapped targets read 0
    always_comb begin
        com_rd = '0;
        if (acc_com) begin
            for (int p = 0; p < PARTS; p++) begin
                if (eng_adr == 7'(p)) begin
                    com_rd = {3'b000, part_omni[p], part_midi_ch[4*p +: 4]};
                end
            end
        end
    end

    // Sequencer: eng_adr/eng_wdata double as the latched access address and data
    always_ff @(posedge reg_clk) begin
        if (!reset_reg_n) begin
            state           <= S_IDLE;
            owner_dec       <= 1'b0;
            acc_write       <= 1'b0;
            acc_com         <= 1'b0;
            wait_cnt        <= '0;
            eng_sel         <= '0;
            eng_adr         <= '0;
            eng_wdata       <= '0;
            eng_write       <= 1'b0;
            eng_read        <= 1'b0;
            cpu_rdata       <= '0;
            dec_rdata       <= '0;
            dec_ack         <= 1'b0;
            cpu_waitrequest <= 1'b1;
            part_omni       <= '0;
            for (int p = 0; p < PARTS; p++) begin
                part_midi_ch[4*p +: 4] <= 4'(p % 16);
            end
`ifdef SYNTH_ARB_FAIR_EN
            starve_left     <= SCW'(STARVE_MAX);
`endif
        end else begin
            eng_write       <= 1'b0;
            eng_read        <= 1'b0;
            dec_ack         <= 1'b0;
            cpu_waitrequest <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (grant_dec || grant_cpu) begin
                        state     <= S_ACCESS;
                        owner_dec <= grant_dec;
                        acc_write <= nx_write;
                        acc_com   <= nx_com;
                        eng_sel   <= nx_eng;
                        eng_adr   <= nx_adr;
                        eng_wdata <= nx_wdata;
                        eng_write <= nx_write & (|nx_eng);
                        eng_read  <= ~nx_write & (|nx_eng);
`ifdef SYNTH_ARB_FAIR_EN
                        if (grant_cpu) begin
                            starve_left <= SCW'(STARVE_MAX);
                        end else if (cpu_req && starve_left != '0) begin
                            starve_left <= starve_left - 1'b1;
                        end
`endif
                    end
                end
                S_ACCESS: begin
                    if (!acc_write && (|eng_sel)) begin
                        wait_cnt <= WCW'(READ_LAT - 1);
                        state    <= S_RD_WAIT;
                    end else begin
                        if (acc_com && acc_write) begin
                            for (int p = 0; p < PARTS; p++) begin
                                if (eng_adr == 7'(p)) begin
                                    part_omni[p]           <= eng_wdata[4];
                                    part_midi_ch[4*p +: 4] <= eng_wdata[3:0];
                                end
                            end
                        end
                        if (!acc_write) begin
                            if (owner_dec) dec_rdata <= com_rd;
                            else           cpu_rdata <= com_rd;
                        end
                        if (owner_dec) dec_ack         <= 1'b1;
                        else           cpu_waitrequest <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        if (owner_dec) begin
                            dec_rdata <= eng_rdata;
                            dec_ack   <= 1'b1;
                        end else begin
                            cpu_rdata       <= eng_rdata;
                            cpu_waitrequest <= 1'b0;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synth_bus_arbiter.sv
// tb_synth_bus_arbiter: scoreboard bench for synth_bus_arbiter (PARTS=4, READ_LAT=3).
// Honours SYNTH_ARB_FAIR_EN for the starvation expectation.
module tb_synth_bus_arbiter;

    localparam int NP     = 4;
    localparam int RL     = 3;
    localparam int LAT_W  = 3;
    localparam int LAT_R  = 3 + RL;
`ifdef SYNTH_ARB_FAIR_EN
    localparam bit FAIR       = 1'b1;
    localparam int STARVE_EXP = 8;
`else
    localparam bit FAIR       = 1'b0;
    localparam int STARVE_EXP = 12;
`endif

    logic            reg_clk = 1'b0;
    logic            reset_reg_n;
    logic            cpu_cs, cpu_read, cpu_write;
    logic [9:0]      cpu_address;
    logic [7:0]      cpu_wdata, cpu_rdata;
    logic            cpu_waitrequest;
    logic            dec_req, dec_rw;
    logic [4:0]      dec_sel;
    logic [6:0]      dec_addr;
    logic [7:0]      dec_wdata, dec_ack_d, dec_rdata;
    logic            dec_ack;
    logic [3:0]      eng_sel;
    logic [6:0]      eng_adr;
    logic            eng_write, eng_read;
    logic [7:0]      eng_wdata, eng_rdata;
    logic [4*NP-1:0] part_midi_ch;
    logic [NP-1:0]   part_omni;

    synth_bus_arbiter #(.PARTS(NP), .READ_LAT(RL), .STARVE_MAX(8)) dut (
        .reg_clk(reg_clk), .reset_reg_n(reset_reg_n),
        .cpu_cs(cpu_cs), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_waitrequest(cpu_waitrequest),
        .dec_req(dec_req), .dec_rw(dec_rw), .dec_sel(dec_sel), .dec_addr(dec_addr),
        .dec_wdata(dec_wdata), .dec_ack(dec_ack), .dec_rdata(dec_rdata),
        .eng_sel(eng_sel), .eng_adr(eng_adr), .eng_write(eng_write), .eng_read(eng_read),
        .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
        .part_midi_ch(part_midi_ch), .part_omni(part_omni)
    );

    always #5 reg_clk = ~reg_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- engine model ----------------
    logic [7:0] eng_mem [4][128] = '{default: '{default: 8'h00}};
    logic [7:0] pd [RL];
    logic       pv [RL];

    function automatic int sel_idx(input logic [3:0] s);
        case (s)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    always @(posedge reg_clk) begin
        if (!reset_reg_n) begin
            for (int i = 0; i < RL; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 8'h00;
            end
        end else begin
            pv[0] <= eng_read;
            pd[0] <= eng_mem[sel_idx(eng_sel)][eng_adr];
            for (int i = 1; i < RL; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (eng_write) eng_mem[sel_idx(eng_sel)][eng_adr] <= eng_wdata;
        end
    end
    assign eng_rdata = pv[RL-1] ? pd[RL-1] : 8'hA5;
    assign dec_ack_d = 8'(dec_ack);

    // ---------------- reference model ----------------
    logic [7:0] exp_mem [4][128] = '{default: '{default: 8'h00}};
    logic [3:0] exp_ch   [NP];
    logic       exp_omni [NP];

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            exp_ch[p]   = 4'(p);
            exp_omni[p] = 1'b0;
        end
    endtask

    function automatic int cpu_tgt(input int region);
        case (region)
            0, 1, 2, 3: return region;
            5:          return 4;
            default:    return 5;
        endcase
    endfunction

    function automatic int dec_tgt(input logic [4:0] sel);
        case (sel)
            5'b00001: return 0;
            5'b00010: return 1;
            5'b00100: return 2;
            5'b01000: return 3;
            5'b10000: return 4;
            default:  return 5;
        endcase
    endfunction

    function automatic logic [7:0] model_rd(input int t, input int adr);
        if (t < 4) return exp_mem[t][adr];
        if (t == 4 && adr < NP) return {3'b000, exp_omni[adr], exp_ch[adr]};
        return 8'h00;
    endfunction

    task automatic model_wr(input int t, input int adr, input logic [7:0] d);
        if (t < 4) exp_mem[t][adr] = d;
        else if (t == 4 && adr < NP) begin
            exp_ch[adr]   = d[3:0];
            exp_omni[adr] = d[4];
        end
    endtask

    function automatic logic [4*NP-1:0] exp_ch_vec();
        logic [4*NP-1:0] v;
        for (int p = 0; p < NP; p++) v[4*p +: 4] = exp_ch[p];
        return v;
    endfunction

    function automatic logic [NP-1:0] exp_omni_vec();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = exp_omni[p];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         is_dec;
        bit         is_read;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input bit is_dec, input bit is_read, input logic [7:0] d);
        exp_t e;
        e.is_dec = is_dec; e.is_read = is_read; e.data = d;
        exp_q.push_back(e);
    endtask

    int         n_eng_wr = 0;
    int         n_eng_rd = 0;
    logic [3:0] last_wr_sel;
    logic [6:0] last_wr_adr;
    logic [7:0] last_wr_dat;

    always @(negedge reg_clk) begin
        if (reset_reg_n) begin
            if (eng_write) begin
                n_eng_wr++;
                last_wr_sel = eng_sel;
                last_wr_adr = eng_adr;
                last_wr_dat = eng_wdata;
            end
            if (eng_read) n_eng_rd++;
            if (dec_ack || !cpu_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk_val("spurious_completion", 32'({dec_ack, ~cpu_waitrequest}), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_val("completion_owner", 32'(dec_ack), 32'(e.is_dec));
                    if (e.is_read) begin
                        if (e.is_dec) chk_val("dec_rdata", 32'(dec_rdata), 32'(e.data));
                        else          chk_val("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_cycle();
        @(posedge reg_clk); #1;
    endtask

    task automatic cpu_xfer(input bit rd, input logic [9:0] a, input logic [7:0] d,
                            input int exp_lat, input int limit);
        int n;
        cpu_cs = 1'b1; cpu_read = rd; cpu_write = ~rd; cpu_address = a; cpu_wdata = d;
        n = 0;
        do begin
            @(posedge reg_clk); #1;
            n++;
        end while (cpu_waitrequest && n < limit);
        if (cpu_waitrequest) chk_val("cpu_timeout", 32'(cpu_waitrequest), 32'd0);
        else if (exp_lat != 0) chk_val("cpu_latency", 32'(n + 1), 32'(exp_lat));
        cpu_cs = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic dec_xfer(input bit rd, input logic [4:0] sel, input logic [6:0] a,
                            input logic [7:0] d, input int exp_lat, input int limit);
        int n;
        dec_req = 1'b1; dec_rw = ~rd; dec_sel = sel; dec_addr = a; dec_wdata = d;
        n = 0;
        do begin
            @(posedge reg_clk); #1;
            n++;
        end while (!dec_ack && n < limit);
        if (!dec_ack) chk_val("dec_timeout", 32'(dec_ack), 32'd1);
        else if (exp_lat != 0) chk_val("dec_latency", 32'(n + 1), 32'(exp_lat));
        dec_req = 1'b0;
    endtask

    task automatic cpu_op(input bit rd, input int region, input int adr, input logic [7:0] d);
        int t;
        t = cpu_tgt(region);
        if (rd) push_exp(1'b0, 1'b1, model_rd(t, adr));
        else begin
            push_exp(1'b0, 1'b0, 8'h00);
            model_wr(t, adr, d);
        end
        cpu_xfer(rd, {3'(region), 7'(adr)}, d, (rd && t < 4) ? LAT_R : LAT_W, 50);
        idle_cycle();
    endtask

    task automatic dec_op(input bit rd, input logic [4:0] sel, input int adr, input logic [7:0] d);
        int t;
        t = dec_tgt(sel);
        if (rd) push_exp(1'b1, 1'b1, model_rd(t, adr));
        else begin
            push_exp(1'b1, 1'b0, 8'h00);
            model_wr(t, adr, d);
        end
        dec_xfer(rd, sel, 7'(adr), d, (rd && t < 4) ? LAT_R : LAT_W, 50);
        idle_cycle();
    endtask

    task automatic check_parts(input string tag);
        chk_val({tag, "_ch"},   32'(part_midi_ch), 32'(exp_ch_vec()));
        chk_val({tag, "_omni"}, 32'(part_omni),    32'(exp_omni_vec()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  wr0, rd0, acks;
        bit  cpu_done;

        reset_reg_n = 1'b0;
        cpu_cs = 0; cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
        dec_req = 0; dec_rw = 0; dec_sel = '0; dec_addr = '0; dec_wdata = '0;
        model_reset();
        repeat (3) @(posedge reg_clk);
        #1;
        chk_val("rst_waitreq",  32'(cpu_waitrequest), 32'd1);
        chk_val("rst_dec_ack",  32'(dec_ack_d),       32'd0);
        chk_val("rst_eng_sel",  32'(eng_sel),         32'd0);
        chk_val("rst_strobes",  32'({eng_write, eng_read}), 32'd0);
        chk_val("rst_rdata",    32'({cpu_rdata, dec_rdata}), 32'd0);
        check_parts("rst");
        reset_reg_n = 1'b1;
        idle_cycle();

        // CPU write to osc, single engine write strobe
        wr0 = n_eng_wr;
        cpu_op(1'b0, 1, 'h11, 8'h2A);
        chk_val("wr_strobe_count", 32'(n_eng_wr - wr0), 32'd1);
        chk_val("wr_strobe_sel",   32'(last_wr_sel), 32'b0010);
        chk_val("wr_strobe_adr",   32'(last_wr_adr), 32'h11);
        chk_val("wr_strobe_dat",   32'(last_wr_dat), 32'h2A);

        // engine reads from both masters
        rd0 = n_eng_rd;
        cpu_op(1'b1, 1, 'h11, 8'h00);
        chk_val("rd_strobe_count", 32'(n_eng_rd - rd0), 32'd1);
        dec_op(1'b0, 5'b00001, 3, 8'h5C);
        cpu_op(1'b1, 0, 3, 8'h00);
        dec_op(1'b1, 5'b00010, 'h11, 8'h00);

        // common registers
        wr0 = n_eng_wr; rd0 = n_eng_rd;
        dec_op(1'b0, 5'b10000, 1, 8'h13);
        check_parts("com_dec_wr");
        dec_op(1'b1, 5'b10000, 1, 8'h00);
        cpu_op(1'b0, 5, 2, 8'hFF);
        cpu_op(1'b1, 5, 2, 8'h00);
        check_parts("com_cpu_wr");
        cpu_op(1'b0, 5, 4, 8'h15);
        cpu_op(1'b1, 5, 4, 8'h00);
        check_parts("com_oob");
        chk_val("com_no_strobes", 32'((n_eng_wr - wr0) + (n_eng_rd - rd0)), 32'd0);

        // unmapped region and invalid decoder selects
        wr0 = n_eng_wr; rd0 = n_eng_rd;
        cpu_op(1'b0, 4, 'h10, 8'h66);
        cpu_op(1'b1, 6, 'h10, 8'h00);
        dec_op(1'b0, 5'b00011, 5, 8'h77);
        dec_op(1'b1, 5'b00000, 5, 8'h00);
        chk_val("unmapped_no_strobes", 32'((n_eng_wr - wr0) + (n_eng_rd - rd0)), 32'd0);

        // simultaneous requests: decoder first, CPU after one idle cycle
        push_exp(1'b1, 1'b0, 8'h00); model_wr(4, 3, 8'h0A);
        push_exp(1'b0, 1'b0, 8'h00); model_wr(3, 'h40, 8'h3C);
        fork
            dec_xfer(1'b0, 5'b10000, 7'd3, 8'h0A, LAT_W, 50);
            cpu_xfer(1'b0, {3'd3, 7'h40}, 8'h3C, 6, 50);
        join
        idle_cycle();
        dec_op(1'b1, 5'b01000, 'h40, 8'h00);
        check_parts("simul");

        // continuous decoder load with a pending CPU write
        for (int i = 0; i < STARVE_EXP; i++) push_exp(1'b1, 1'b0, 8'h00);
        push_exp(1'b0, 1'b0, 8'h00);
        model_wr(0, 'h20, 8'h44);
        model_wr(1, 5, 8'h99);
        dec_rw = 1'b1; dec_sel = 5'b00001; dec_addr = 7'h20; dec_wdata = 8'h44;
        dec_req = 1'b1; cpu_done = 1'b0; acks = 0;
        fork
            begin
                cpu_xfer(1'b0, {3'd1, 7'h05}, 8'h99, 0, 400);
                cpu_done = 1'b1;
            end
            begin
                for (int k = 0; k < 400; k++) begin
                    @(posedge reg_clk); #2;
                    if (dec_ack) acks++;
                    if (cpu_done || (!FAIR && acks >= STARVE_EXP)) break;
                end
                dec_req = 1'b0;
            end
        join
        idle_cycle();
        chk_val("starve_dec_grants", 32'(acks), 32'(STARVE_EXP));
        cpu_op(1'b1, 1, 5, 8'h00);

        // decoder drops its request after one cycle: access still completes
        push_exp(1'b1, 1'b0, 8'h00); model_wr(1, 7, 8'h77);
        dec_rw = 1'b1; dec_sel = 5'b00010; dec_addr = 7'd7; dec_wdata = 8'h77; dec_req = 1'b1;
        idle_cycle();
        dec_req = 1'b0; dec_sel = '0; dec_addr = '0; dec_wdata = '0;
        repeat (4) idle_cycle();
        cpu_op(1'b1, 1, 7, 8'h00);

        // reset during RD_WAIT aborts without completion
        dec_rw = 1'b0; dec_sel = 5'b00100; dec_addr = 7'h10; dec_req = 1'b1;
        repeat (3) idle_cycle();
        reset_reg_n = 1'b0;
        dec_req = 1'b0;
        idle_cycle();
        model_reset();
        chk_val("abort_dec_ack",  32'(dec_ack_d),       32'd0);
        chk_val("abort_waitreq",  32'(cpu_waitrequest), 32'd1);
        chk_val("abort_eng",      32'({eng_sel, eng_adr, eng_wdata, eng_write, eng_read}), 32'd0);
        chk_val("abort_rdata",    32'({cpu_rdata, dec_rdata}), 32'd0);
        check_parts("abort");
        reset_reg_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            idle_cycle();
            if (dec_ack) acks++;
        end
        chk_val("abort_no_ack", 32'(acks), 32'd0);
        dec_op(1'b1, 5'b10000, 1, 8'h00);

        repeat (3) idle_cycle();
        chk_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
